// File: rtl/fp_pkg.sv
// Shared types and default widths for the sequential floating-point adder.
package fp_pkg;

   localparam int FP_MW_DEF = 16;
   localparam int FP_EW_DEF = 8;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_ALIGN = 3'd1,
      S_ADD   = 3'd2,
      S_NORM  = 3'd3,
      S_DONE  = 3'd4
   } fp_state_e;

endpackage

// File: rtl/fp_align_shift.sv
// Combinational operand ordering and mantissa alignment for the ALIGN step.
module fp_align_shift
   import fp_pkg::*;
#(
   parameter int MW = FP_MW_DEF,
   parameter int EW = FP_EW_DEF
) (
   input  logic          sign_a_i,
   input  logic [MW-1:0] man_a_i,
   input  logic [EW-1:0] exp_a_i,
   input  logic          sign_b_i,
   input  logic [MW-1:0] man_b_i,
   input  logic [EW-1:0] exp_b_i,
   output logic          sign_l_o,
   output logic [MW-1:0] man_l_o,
   output logic          sign_s_o,
   output logic [MW-1:0] man_s_o,
   output logic [EW-1:0] exp_l_o
);

   logic [MW-1:0] man_s_raw_s;
   logic [EW-1:0] exp_s_s;
   logic [EW-1:0] dist_s;

   // Order operands by exponent, then shift the smaller one into alignment
   always_comb begin
      if (exp_a_i >= exp_b_i) begin
         sign_l_o    = sign_a_i;
         man_l_o     = man_a_i;
         exp_l_o     = exp_a_i;
         sign_s_o    = sign_b_i;
         man_s_raw_s = man_b_i;
         exp_s_s     = exp_b_i;
      end else begin
         sign_l_o    = sign_b_i;
         man_l_o     = man_b_i;
         exp_l_o     = exp_b_i;
         sign_s_o    = sign_a_i;
         man_s_raw_s = man_a_i;
         exp_s_s     = exp_a_i;
      end
      dist_s = exp_l_o - exp_s_s;
      // Distances at or beyond the mantissa width flush the small operand
      if (32'(dist_s) >= MW) begin
         man_s_o = {MW{1'b0}};
      end else begin
         man_s_o = man_s_raw_s >> dist_s;
      end
   end

endmodule

// File: rtl/fp_add_seq.sv
// Multi-cycle add of sign/magnitude floats (value = (-1)^s * m * 2^e).
// Define FP_ADD_SEQ_SUB_EN to add the op_sub input that turns the operation into a-b.
module fp_add_seq
   import fp_pkg::*;
#(
   parameter int MW = FP_MW_DEF,
   parameter int EW = FP_EW_DEF
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   output logic          in_ready,
`ifdef FP_ADD_SEQ_SUB_EN
   input  logic          op_sub,
`endif
   input  logic          sign_a,
   input  logic          sign_b,
   input  logic [MW-1:0] man_a,
   input  logic [MW-1:0] man_b,
   input  logic [EW-1:0] exp_a,
   input  logic [EW-1:0] exp_b,
   output logic          out_valid,
   input  logic          out_ready,
   output logic          sign_o,
   output logic [MW-1:0] man_o,
   output logic [EW-1:0] exp_o,
   output logic          ovf
);

   fp_state_e     state_q;
   logic          in_ready_q;
   logic          out_valid_q;
   logic          sign_o_q;
   logic [MW-1:0] man_o_q;
   logic [EW-1:0] exp_o_q;
   logic          ovf_q;

   logic          sign_a_q, sign_b_q;
   logic [MW-1:0] man_a_q, man_b_q;
   logic [EW-1:0] exp_a_q, exp_b_q;

   logic          sign_l_q, sign_s_q;
   logic [MW-1:0] man_l_q, man_s_q;
   logic [EW-1:0] exp_l_q;

   logic          sign_w_q;
   logic [MW-1:0] man_w_q;
   logic [EW-1:0] exp_w_q;
   logic          ovf_w_q;

   logic          align_sign_l_s, align_sign_s_s;
   logic [MW-1:0] align_man_l_s, align_man_s_s;
   logic [EW-1:0] align_exp_l_s;

   logic          sign_b_in_s;
   logic [MW:0]   sum_s;
   logic          add_sign_d;
   logic [MW-1:0] add_man_d;
   logic [EW-1:0] add_exp_d;
   logic          add_ovf_d;
   logic          norm_shift_s;

`ifdef FP_ADD_SEQ_SUB_EN
   assign sign_b_in_s = sign_b ^ op_sub;
`else
   assign sign_b_in_s = sign_b;
`endif

   fp_align_shift #(
      .MW (MW),
      .EW (EW)
   ) u_align (
      .sign_a_i (sign_a_q),
      .man_a_i  (man_a_q),
      .exp_a_i  (exp_a_q),
      .sign_b_i (sign_b_q),
      .man_b_i  (man_b_q),
      .exp_b_i  (exp_b_q),
      .sign_l_o (align_sign_l_s),
      .man_l_o  (align_man_l_s),
      .sign_s_o (align_sign_s_s),
      .man_s_o  (align_man_s_s),
      .exp_l_o  (align_exp_l_s)
   );

   // Magnitude add/subtract with carry renormalisation and exponent saturation
   always_comb begin
      if (sign_l_q == sign_s_q) begin
         sum_s      = {1'b0, man_l_q} + {1'b0, man_s_q};
         add_sign_d = sign_l_q;
      end else if (man_l_q >= man_s_q) begin
         sum_s      = {1'b0, man_l_q} - {1'b0, man_s_q};
         add_sign_d = sign_l_q;
      end else begin
         sum_s      = {1'b0, man_s_q} - {1'b0, man_l_q};
         add_sign_d = sign_s_q;
      end
      add_ovf_d = 1'b0;
      if (sum_s[MW]) begin
         if (exp_l_q == {EW{1'b1}}) begin
            add_man_d = {MW{1'b1}};
            add_exp_d = {EW{1'b1}};
            add_ovf_d = 1'b1;
         end else begin
            add_man_d = sum_s[MW:1];
            add_exp_d = exp_l_q + {{(EW-1){1'b0}}, 1'b1};
         end
      end else if (sum_s[MW-1:0] == {MW{1'b0}}) begin
         add_man_d  = {MW{1'b0}};
         add_exp_d  = {EW{1'b0}};
         add_sign_d = 1'b0;
      end else begin
         add_man_d = sum_s[MW-1:0];
         add_exp_d = exp_l_q;
      end
   end

   assign norm_shift_s = (man_w_q != {MW{1'b0}}) && !man_w_q[MW-1] &&
                         (exp_w_q != {EW{1'b0}});

   // Control FSM together with all datapath and output registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         sign_o_q    <= 1'b0;
         man_o_q     <= {MW{1'b0}};
         exp_o_q     <= {EW{1'b0}};
         ovf_q       <= 1'b0;
         sign_a_q    <= 1'b0;
         sign_b_q    <= 1'b0;
         man_a_q     <= {MW{1'b0}};
         man_b_q     <= {MW{1'b0}};
         exp_a_q     <= {EW{1'b0}};
         exp_b_q     <= {EW{1'b0}};
         sign_l_q    <= 1'b0;
         sign_s_q    <= 1'b0;
         man_l_q     <= {MW{1'b0}};
         man_s_q     <= {MW{1'b0}};
         exp_l_q     <= {EW{1'b0}};
         sign_w_q    <= 1'b0;
         man_w_q     <= {MW{1'b0}};
         exp_w_q     <= {EW{1'b0}};
         ovf_w_q     <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (in_valid && in_ready_q) begin
                  sign_a_q   <= sign_a;
                  sign_b_q   <= sign_b_in_s;
                  man_a_q    <= man_a;
                  man_b_q    <= man_b;
                  exp_a_q    <= exp_a;
                  exp_b_q    <= exp_b;
                  in_ready_q <= 1'b0;
                  ovf_q      <= 1'b0;
                  state_q    <= S_ALIGN;
               end
            end
            S_ALIGN: begin
               sign_l_q <= align_sign_l_s;
               sign_s_q <= align_sign_s_s;
               man_l_q  <= align_man_l_s;
               man_s_q  <= align_man_s_s;
               exp_l_q  <= align_exp_l_s;
               state_q  <= S_ADD;
            end
            S_ADD: begin
               sign_w_q <= add_sign_d;
               man_w_q  <= add_man_d;
               exp_w_q  <= add_exp_d;
               ovf_w_q  <= add_ovf_d;
               state_q  <= S_NORM;
            end
            S_NORM: begin
               if (norm_shift_s) begin
                  man_w_q <= {man_w_q[MW-2:0], 1'b0};
                  exp_w_q <= exp_w_q - {{(EW-1){1'b0}}, 1'b1};
               end else begin
                  state_q <= S_DONE;
               end
            end
            S_DONE: begin
               // First DONE cycle publishes the result; later cycles wait for the consumer
               if (!out_valid_q) begin
                  sign_o_q    <= sign_w_q;
                  man_o_q     <= man_w_q;
                  exp_o_q     <= exp_w_q;
                  ovf_q       <= ovf_w_q;
                  out_valid_q <= 1'b1;
               end else if (out_ready) begin
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
                  state_q     <= S_IDLE;
               end
            end
            default: begin
               state_q     <= S_IDLE;
               in_ready_q  <= 1'b1;
               out_valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign sign_o    = sign_o_q;
   assign man_o     = man_o_q;
   assign exp_o     = exp_o_q;
   assign ovf       = ovf_q;

endmodule

// File: tb/tb_fp_add_seq.sv
// Scoreboard bench for fp_add_seq: directed vectors, expected results queued at accept time.
module tb_fp_add_seq;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic        op_sub;
   logic        sign_a, sign_b;
   logic [15:0] man_a, man_b;
   logic [7:0]  exp_a, exp_b;
   logic        out_valid;
   logic        out_ready;
   logic        sign_o;
   logic [15:0] man_o;
   logic [7:0]  exp_o;
   logic        ovf;

   typedef struct {
      string       nm;
      logic        s;
      logic [15:0] m;
      logic [7:0]  e;
      logic        o;
      int          lat;
      int          acc;
   } exp_t;

   exp_t sb_q[$];
   int   total = 0;
   int   bad   = 0;
   int   cyc   = 0;
   logic prev_v = 1'b0;

   fp_add_seq #(.MW(16), .EW(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
`ifdef FP_ADD_SEQ_SUB_EN
      .op_sub    (op_sub),
`endif
      .sign_a    (sign_a),
      .sign_b    (sign_b),
      .man_a     (man_a),
      .man_b     (man_b),
      .exp_a     (exp_a),
      .exp_b     (exp_b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sign_o    (sign_o),
      .man_o     (man_o),
      .exp_o     (exp_o),
      .ovf       (ovf)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0h required %0h", name, act, req);
      end
   endtask

   // Monitor: compare each newly presented result against the oldest expectation
   always @(negedge clk) begin
      exp_t x;
      if (out_valid && !prev_v) begin
         if (sb_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_result: got man=%0h exp=%0h, required no result", man_o, exp_o);
         end else begin
            x = sb_q.pop_front();
            check({x.nm, "_result"}, {38'd0, sign_o, man_o, exp_o, ovf}, {38'd0, x.s, x.m, x.e, x.o});
            check({x.nm, "_latency"}, 64'(cyc - x.acc), 64'(x.lat));
         end
      end
      prev_v <= out_valid;
   end

   task automatic send(input string nm,
                       input logic sa, input logic [15:0] ma, input logic [7:0] ea,
                       input logic sb, input logic [15:0] mb, input logic [7:0] eb,
                       input logic osub,
                       input logic es, input logic [15:0] em, input logic [7:0] ee,
                       input logic eo, input int lat, input bit push);
      int   guard = 0;
      exp_t x;
      @(negedge clk);
      while (!in_ready && guard < 200) begin
         @(negedge clk);
         guard++;
      end
      if (!in_ready) begin
         total++;
         bad++;
         $display("FAIL %s_accept_timeout: got in_ready=0, required 1", nm);
         return;
      end
      sign_a = sa; man_a = ma; exp_a = ea;
      sign_b = sb; man_b = mb; exp_b = eb;
      op_sub = osub;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      man_a = 16'hA5A5; man_b = 16'h5A5A; exp_a = 8'hEE; exp_b = 8'h11;
      sign_a = ~sa; sign_b = ~sb;
      if (push) begin
         x.nm = nm; x.s = es; x.m = em; x.e = ee; x.o = eo; x.lat = lat; x.acc = cyc;
         sb_q.push_back(x);
      end
   endtask

   task automatic wait_idle(input string nm);
      int g = 0;
      while ((sb_q.size() != 0 || out_valid) && g < 100) begin
         @(negedge clk);
         g++;
      end
      if (sb_q.size() != 0 || out_valid) begin
         total++;
         bad++;
         $display("FAIL %s_drain_timeout: got %0d pending, required 0", nm, sb_q.size());
         sb_q.delete();
      end
   endtask

   initial begin
      int seen;
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; op_sub = 1'b0;
      sign_a = 1'b0; sign_b = 1'b0; man_a = 16'h0; man_b = 16'h0; exp_a = 8'h0; exp_b = 8'h0;
      #12;
      check("reset_state", {58'd0, in_ready, out_valid, sign_o, ovf, man_o == 16'h0, exp_o == 8'h0},
            {58'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1});
      @(negedge clk);
      rst = 1'b0;

      send("add_carry",   1'b0, 16'h8000, 8'd10,  1'b0, 16'h8000, 8'd10,  1'b0, 1'b0, 16'h8000, 8'd11,  1'b0, 4, 1'b1);
      send("sub_same",    1'b0, 16'hC000, 8'd5,   1'b1, 16'h4000, 8'd5,   1'b0, 1'b0, 16'h8000, 8'd5,   1'b0, 4, 1'b1);
      send("align3",      1'b0, 16'h8000, 8'd20,  1'b0, 16'h8000, 8'd17,  1'b0, 1'b0, 16'h9000, 8'd20,  1'b0, 4, 1'b1);
      send("norm15",      1'b0, 16'h0001, 8'd20,  1'b0, 16'h0000, 8'd0,   1'b0, 1'b0, 16'h8000, 8'd5,   1'b0, 19, 1'b1);
      send("norm_floor",  1'b0, 16'h0001, 8'd3,   1'b0, 16'h0000, 8'd0,   1'b0, 1'b0, 16'h0008, 8'd0,   1'b0, 7, 1'b1);
      send("cancel",      1'b0, 16'h1234, 8'd7,   1'b1, 16'h1234, 8'd7,   1'b0, 1'b0, 16'h0000, 8'd0,   1'b0, 4, 1'b1);
      send("swap_neg",    1'b0, 16'h4000, 8'd2,   1'b1, 16'h8000, 8'd3,   1'b0, 1'b1, 16'hC000, 8'd2,   1'b0, 5, 1'b1);
      send("shift15",     1'b0, 16'h8000, 8'd30,  1'b0, 16'hFFFF, 8'd15,  1'b0, 1'b0, 16'h8001, 8'd30,  1'b0, 4, 1'b1);
      send("shift16",     1'b0, 16'h8000, 8'd30,  1'b0, 16'hFFFF, 8'd14,  1'b0, 1'b0, 16'h8000, 8'd30,  1'b0, 4, 1'b1);
      send("overflow",    1'b0, 16'h8000, 8'd255, 1'b0, 16'h8000, 8'd255, 1'b0, 1'b0, 16'hFFFF, 8'd255, 1'b1, 4, 1'b1);
      wait_idle("overflow");
      send("after_ovf",   1'b1, 16'h8000, 8'd4,   1'b1, 16'h0000, 8'd0,   1'b0, 1'b1, 16'h8000, 8'd4,   1'b0, 4, 1'b1);
      check("ovf_cleared_on_accept", {63'd0, ovf}, 64'd0);
      wait_idle("after_ovf");

      // Consumer stalls in DONE while junk operands are offered
      out_ready = 1'b0;
      send("hold",        1'b0, 16'h8000, 8'd10,  1'b0, 16'h8000, 8'd10,  1'b0, 1'b0, 16'h8000, 8'd11,  1'b0, 4, 1'b1);
      seen = 0;
      while (!out_valid && seen < 30) begin
         @(negedge clk);
         seen++;
      end
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         in_valid = 1'b1; man_a = 16'h1111; exp_a = 8'd1; man_b = 16'h2222; exp_b = 8'd2;
         check("hold_stable", {37'd0, out_valid, in_ready, sign_o, man_o, exp_o},
               {37'd0, 1'b1, 1'b0, 1'b0, 16'h8000, 8'd11});
      end
      in_valid = 1'b0;
      @(negedge clk);
      out_ready = 1'b1;
      send("post_hold",   1'b0, 16'h4000, 8'd6,   1'b0, 16'h4000, 8'd6,   1'b0, 1'b0, 16'h8000, 8'd6,   1'b0, 4, 1'b1);
      wait_idle("post_hold");

      // Reset in the middle of a long normalisation
      send("norm_rst",    1'b0, 16'h0001, 8'd20,  1'b0, 16'h0000, 8'd0,   1'b0, 1'b0, 16'h8000, 8'd5,   1'b0, 19, 1'b0);
      repeat (6) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      check("rst_midop_outputs", {40'd0, out_valid, in_ready, sign_o, ovf, man_o, exp_o},
            {40'd0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 8'd0});
      @(negedge clk);
      rst = 1'b0;
      seen = 0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (out_valid) seen++;
      end
      check("rst_no_partial", 64'(seen), 64'd0);
      send("after_rst",   1'b0, 16'h0001, 8'd3,   1'b0, 16'h0000, 8'd0,   1'b0, 1'b0, 16'h0008, 8'd0,   1'b0, 7, 1'b1);
`ifdef FP_ADD_SEQ_SUB_EN
      send("op_sub",      1'b0, 16'h8000, 8'd4,   1'b0, 16'h8000, 8'd4,   1'b1, 1'b0, 16'h0000, 8'd0,   1'b0, 4, 1'b1);
`endif
      wait_idle("final");
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/fp_add_seq.md
FP_ADD_SEQ -- requirements
Module: fp_add_seq

Interface
REQ-001 Parameter MW, default 16: mantissa width in bits (unsigned magnitude integer, no hidden bit).
REQ-002 Parameter EW, default 8: exponent width in bits (unsigned, no bias); value = (-1)^s * m * 2^e.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 in_valid  input  1  operand pair presented.
REQ-006 in_ready  output  1  block can accept operands.
REQ-007 sign_a, sign_b  input  1 each  operand signs.
REQ-008 man_a, man_b  input  MW each  operand mantissas.
REQ-009 exp_a, exp_b  input  EW each  operand exponents.
REQ-010 out_valid  output  1  result available.
REQ-011 out_ready  input  1  consumer accepts result.
REQ-012 sign_o, man_o, exp_o  output  1/MW/EW  result.
REQ-013 ovf  output  1  exponent overflow on the current result.

Function
REQ-014 FSM states: IDLE, ALIGN, ADD, NORM, DONE; in_ready=1 only in IDLE.
REQ-015 IDLE: on in_valid&&in_ready, register all operands and go to ALIGN.
REQ-016 ALIGN (1 cycle): swap so operand L has exponent >= S's; shift S mantissa right by (exp_L-exp_S), truncating; shift >= MW yields 0; working exponent = exp_L.
REQ-017 ADD (1 cycle): equal signs -> add magnitudes; differing -> larger magnitude minus smaller, sign of larger; a carry-out shifts right 1 (LSB dropped) and increments exponent.
REQ-018 ADD overflow: carry-out with exponent already all-ones -> man=all-ones, exp=all-ones, ovf=1.
REQ-019 NORM: per cycle, if mantissa nonzero, MSB=0 and exponent>0, shift left 1 and decrement exponent; otherwise go to DONE.
REQ-020 Zero result (mantissa 0 after ADD): sign=0, exp=0, exits NORM in one cycle.
REQ-021 Latency: out_valid rises 4 cycles after the accepting edge plus k, k = number of NORM shifts (0..MW-1).
REQ-022 DONE: out_valid=1 and outputs held stable until out_ready; on out_valid&&out_ready return to IDLE; in_ready returns the following cycle (no same-cycle reaccept).
REQ-023 in_valid outside IDLE is ignored; operand inputs are sampled only at the accepting edge.
REQ-024 ovf is valid only with out_valid and is cleared on acceptance of a new operand pair.

Reset
REQ-025 rst asserted: state=IDLE, in_ready=1, out_valid=0, sign_o=0, man_o=0, exp_o=0, ovf=0, immediately and asynchronously.
REQ-026 rst mid-operation discards the in-flight operation; no partial result appears afterwards.

Configuration
REQ-027 Macro FP_ADD_SEQ_SUB_EN: when defined, adds input op_sub (1 bit, sampled with operands); op_sub=1 inverts sign_b before ALIGN, giving a-b.
REQ-028 Without FP_ADD_SEQ_SUB_EN: no op_sub port; block always adds.

Structure
REQ-029 Shared package fp_pkg holds the FSM state enum and default MW/EW constants.
REQ-030 One sub-module fp_align_shift: combinational swap plus right-shift of ALIGN; all state in fp_add_seq.

Verification
REQ-031 a=(+,0x8000,e10), b=(+,0x8000,e10) -> (+,0x8000,e11), ovf=0, out_valid 4 cycles after accept.
REQ-032 a=(+,0xC000,e5), b=(-,0x4000,e5) -> (+,0x8000,e5); a=(+,0x8000,e20), b=(+,0x8000,e17) -> (+,0x9000,e20).
REQ-033 a=(+,0x0001,e20), b=(+,0x0000,e0) -> (+,0x8000,e5) after 19 cycles; a=(+,0x0001,e3), b=0 -> (+,0x0008,e0).
REQ-034 a=(+,0x1234,e7), b=(-,0x1234,e7) -> (+,0x0000,e0); a=b=(+,0x8000,e255) -> man 0xFFFF, exp 255, ovf=1.
REQ-035 Hold out_ready=0 for 10 cycles in DONE -> outputs stable, in_ready=0, new in_valid ignored; then accept, next op proceeds.
REQ-036 rst pulsed during NORM -> all outputs zero, in_ready=1; next operation's result correct and unaffected; with macro, op_sub=1 on a=(+,0x8000,e4), b=(+,0x8000,e4) -> zero result.
